// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings,
// default latencies and the controller state encoding.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_alu.sv
// Combinational multiply/divide datapath; result is packed as {hi, lo}.
module mdu_alu
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [63:0] result,
  output logic        div0
);

  logic signed [63:0] rs_ext;
  logic signed [63:0] rt_ext;
  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;

  assign rs_ext = {{32{rs_val[31]}}, rs_val};
  assign rt_ext = {{32{rt_val[31]}}, rt_val};
  assign rs_s   = rs_val;
  assign rt_s   = rt_val;

  always_comb begin
    result = '0;
    div0   = 1'b0;
    quo_s  = '0;
    rem_s  = '0;
    case (op)
      OP_MULT:  result = rs_ext * rt_ext;
      OP_MULTU: result = {32'd0, rs_val} * {32'd0, rt_val};
      OP_DIV: begin
        if (rt_val == 32'd0) begin
          div0 = 1'b1;
        end else if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
          // The one signed quotient that overflows 32 bits wraps to itself.
          result = {32'd0, 32'h8000_0000};
        end else begin
          quo_s  = rs_s / rt_s;
          rem_s  = rs_s % rt_s;
          result = {rem_s, quo_s};
        end
      end
      OP_DIVU: begin
        if (rt_val == 32'd0) begin
          div0 = 1'b1;
        end else begin
          result = {rs_val % rt_val, rs_val / rt_val};
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: issue FSM, latency counter, pending result and the
// architectural HI/LO registers, plus the pipeline stall request.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [63:0]      pend, pend_nxt;
  logic             pend_wr, pend_wr_nxt;
  logic [31:0]      hi_nxt, lo_nxt;
  logic [63:0]      alu_result;
  logic             alu_div0;

  mdu_alu u_alu (
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .result (alu_result),
    .div0   (alu_div0)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_nxt    = pend;
    pend_wr_nxt = pend_wr;
    hi_nxt      = hi;
    lo_nxt      = lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_nxt   = ST_MUL;
              cnt_nxt     = CNT_W'(MUL_CYCLES);
              pend_nxt    = alu_result;
              pend_wr_nxt = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_nxt   = ST_DIV;
              cnt_nxt     = CNT_W'(DIV_CYCLES);
              pend_nxt    = alu_result;
              // A zero divisor still occupies the unit but must not retire.
              pend_wr_nxt = ~alu_div0;
            end
            OP_MTHI: hi_nxt = rs_val;
            OP_MTLO: lo_nxt = rs_val;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          if (pend_wr) begin
            {hi_nxt, lo_nxt} = pend;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend    <= pend_nxt;
      pend_wr <= pend_wr_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
    end
  end

  assign busy  = (state != ST_IDLE);
  assign stall = md_use & (busy | (start & ~op[2]));

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage MDU instruction issue, one-cycle pulse.
REQ-006 SHALL have port op  input  3  MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6-7 reserved.
REQ-007 SHALL have port rs_val  input  32  first operand, or MTHI/MTLO data.
REQ-008 SHALL have port rt_val  input  32  second operand (divisor for DIV/DIVU).
REQ-009 SHALL have port md_use  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port hi  output  32  HI register.
REQ-011 SHALL have port lo  output  32  LO register.
REQ-012 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-013 SHALL have port stall  output  1  freeze F/D stages, bubble into E.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV; busy=1 exactly when state is MUL or DIV.
REQ-015 IDLE, start=1, op MULT/MULTU: SHALL go to MUL, load counter with MUL_CYCLES, latch the 64-bit product in a pending register.
REQ-016 IDLE, start=1, op DIV/DIVU: SHALL go to DIV, load counter with DIV_CYCLES, latch quotient/remainder pending.
REQ-017 In MUL/DIV, counter SHALL decrement each edge; at the edge with counter==1, pending SHALL be written to HI/LO and state SHALL return to IDLE.
REQ-018 busy SHALL be high for exactly MUL_CYCLES/DIV_CYCLES cycles after the start edge; new HI/LO SHALL be visible in the first cycle busy is low.
REQ-019 MULT SHALL be signed 32x32->64 ({hi,lo}); MULTU SHALL be unsigned.
REQ-020 DIV SHALL be signed, truncating toward zero: lo=quotient, hi=remainder carrying the dividend's sign; DIVU SHALL be unsigned.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-022 Divisor==0: SHALL stay busy DIV_CYCLES cycles and SHALL leave HI/LO unchanged.
REQ-023 IDLE, start=1, op MTHI/MTLO: SHALL write rs_val to hi/lo at that edge; no busy.
REQ-024 start while busy SHALL be ignored and SHALL NOT change state, counter, pending or HI/LO.
REQ-025 start with reserved op SHALL be ignored.
REQ-026 stall SHALL equal md_use & (busy | (start & op<=3)); combinational, no added latency.
REQ-027 MFHI/MFLO SHALL read hi/lo directly; in-flight results SHALL NOT be forwarded.

Reset
REQ-028 On reset low, asynchronously: state=IDLE, counter=0, pending=0, hi=0, lo=0, busy=0.
REQ-029 Reset mid-operation SHALL abort it; HI/LO SHALL read 0, never the pending result.
REQ-030 After reset deasserts, start SHALL be accepted at the first rising edge.

Structure
REQ-031 Package mdu_pkg SHALL hold the op encodings, default MUL_CYCLES/DIV_CYCLES and the state encoding.
REQ-032 Arithmetic SHALL be a combinational sub-module mdu_alu (op, rs_val, rt_val -> 64-bit result, div0 flag); mdu_ctrl holds FSM, counter and registers.

Verification
REQ-033 MULT rs=0xFFFFFFFE (-2), rt=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-034 DIV rs=-7, rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-035 MTHI rs=0x12345678 with md_use=0 -> hi=0x12345678 next cycle, busy never set, stall=0.
REQ-036 DIV then md_use=1 -> stall=1 on the issue cycle and all 10 busy cycles, 0 in the cycle after; second start mid-busy -> ignored.
REQ-037 DIV by 0 with hi=lo=0x0000AAAA -> busy 10 cycles, hi/lo remain 0x0000AAAA.
REQ-038 MULT started, reset pulsed low at busy cycle 3 -> busy=0 and hi=lo=0 immediately, and they remain 0 after the original completion time.
